// File: rtl/ara_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ara_pkg
// Description : Shared types and helpers for the VRF bank request generator.
//               Holds the traffic modes, the FSM state encoding and the
//               16-bit Fibonacci LFSR that is used in random mode.
// Revision    : 1.0 - initial release
// ============================================================================
package ara_pkg;

    // How a channel chooses its next bank
    typedef enum logic [1:0] {
        GEN_ROTATE  = 2'd0,
        GEN_HOTSPOT = 2'd1,
        GEN_RANDOM  = 2'd2,
        GEN_RSVD    = 2'd3
    } gen_mode_e;

    // Top-level run control
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } gen_state_e;

    localparam int unsigned c_lfsr_width = 16;

    // x^16 + x^14 + x^13 + x^11, shifting toward the MSB
    function automatic logic [c_lfsr_width-1:0] lfsr_next(input logic [c_lfsr_width-1:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

    // An all-zero state would lock the LFSR, so it is replaced by 1
    function automatic logic [c_lfsr_width-1:0] lfsr_seed(input logic [c_lfsr_width-1:0] s);
        return (s == '0) ? 16'h0001 : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/vrf_req_chan.sv
`default_nettype none
// ============================================================================
// Module      : vrf_req_chan
// Description : One requester column. Keeps the remaining request budget, the
//               grant count k, the LFSR and the one-hot bank request, which is
//               held stable until a matching grant is seen.
// Revision    : 1.0 - initial release
// ============================================================================
module vrf_req_chan
    import ara_pkg::*;
#(
    parameter int unsigned NR_BANKS  = 8,
    parameter int unsigned CNT_WIDTH = 16,
    parameter int unsigned REQ_ID    = 0,
    localparam int unsigned BANK_W   = $clog2(NR_BANKS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_load,
    input  logic                 i_clear,
    input  logic [CNT_WIDTH-1:0] i_budget,
    input  gen_mode_e            i_mode,
    input  logic [BANK_W-1:0]    i_hot_bank,
    input  logic [15:0]          i_seed,
    input  logic [NR_BANKS-1:0]  i_gnt,
    output logic [NR_BANKS-1:0]  o_req,
    output logic                 o_granted,
    output logic                 o_empty
);

    localparam logic [BANK_W-1:0] c_id = BANK_W'(REQ_ID % NR_BANKS);

    logic [CNT_WIDTH-1:0] r_budget;
    logic [CNT_WIDTH-1:0] r_k;
    logic [15:0]          r_lfsr;
    logic [NR_BANKS-1:0]  r_req;
    gen_mode_e            r_mode;
    logic [BANK_W-1:0]    r_hot_bank;

    logic [15:0]          w_lfsr_load;
    logic [15:0]          w_lfsr_step;
    logic [CNT_WIDTH-1:0] w_k_step;
    logic [NR_BANKS-1:0]  w_req_load;
    logic [NR_BANKS-1:0]  w_req_step;
    logic                 w_granted;

    function automatic logic [BANK_W-1:0] f_bank(input gen_mode_e mode,
                                                 input logic [BANK_W-1:0] k_lo,
                                                 input logic [BANK_W-1:0] lfsr_lo,
                                                 input logic [BANK_W-1:0] hot);
        case (mode)
            GEN_HOTSPOT: f_bank = hot;
            GEN_RANDOM:  f_bank = lfsr_lo;
            default:     f_bank = c_id + k_lo;  // wraps modulo NR_BANKS
        endcase
    endfunction

    function automatic logic [NR_BANKS-1:0] f_onehot(input logic [BANK_W-1:0] b);
        f_onehot    = '0;
        f_onehot[b] = 1'b1;
    endfunction

    // First request of a run and the follow-on request after each grant
    always_comb begin
        w_lfsr_load = lfsr_seed(i_seed ^ 16'(REQ_ID));
        w_lfsr_step = lfsr_next(r_lfsr);
        w_k_step    = r_k + CNT_WIDTH'(1);
        w_granted   = |(i_gnt & r_req);
        w_req_load  = (i_budget != '0)
                    ? f_onehot(f_bank(i_mode, '0, w_lfsr_load[BANK_W-1:0], i_hot_bank))
                    : '0;
        w_req_step  = (r_budget != CNT_WIDTH'(1))
                    ? f_onehot(f_bank(r_mode, w_k_step[BANK_W-1:0], w_lfsr_step[BANK_W-1:0], r_hot_bank))
                    : '0;
    end

    // Channel state: clear beats load, load beats grant consumption
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_budget   <= '0;
            r_k        <= '0;
            r_lfsr     <= 16'h0001;
            r_req      <= '0;
            r_mode     <= GEN_ROTATE;
            r_hot_bank <= '0;
        end else if (i_clear) begin
            r_budget <= '0;
            r_req    <= '0;
        end else if (i_load) begin
            r_budget   <= i_budget;
            r_k        <= '0;
            r_lfsr     <= w_lfsr_load;
            r_req      <= w_req_load;
            r_mode     <= i_mode;
            r_hot_bank <= i_hot_bank;
        end else if (w_granted) begin
            r_budget <= r_budget - CNT_WIDTH'(1);
            r_k      <= w_k_step;
            r_lfsr   <= w_lfsr_step;
            r_req    <= w_req_step;
        end
    end

    assign o_req     = r_req;
    assign o_granted = w_granted;
    assign o_empty   = (r_budget == '0);

endmodule
`default_nettype wire

// File: rtl/vrf_bank_req_gen.sv
`default_nettype none
// ============================================================================
// Module      : vrf_bank_req_gen
// Description : Drives per-bank operand request vectors for all lane operand
//               queues and global masters, holding each request until it is
//               granted. Tracks issued grants, stalled requester-cycles and
//               unexpected grants.
// Revision    : 1.0 - initial release
// ============================================================================
module vrf_bank_req_gen
    import ara_pkg::*;
#(
    parameter int unsigned NR_BANKS          = 8,
    parameter int unsigned NR_OPERAND_QUEUES = 9,
    parameter int unsigned NR_GLOBAL_MASTERS = 5,
    parameter int unsigned CNT_WIDTH         = 16,
    localparam int unsigned NR_REQ           = NR_OPERAND_QUEUES + NR_GLOBAL_MASTERS,
    localparam int unsigned BANK_W           = $clog2(NR_BANKS)
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    input  logic                                         start_i,
    input  logic                                         abort_i,
    input  logic [1:0]                                   mode_i,
    input  logic [BANK_W-1:0]                            hot_bank_i,
    input  logic [15:0]                                  seed_i,
    input  logic [CNT_WIDTH-1:0]                         num_req_i,
    input  logic [NR_REQ-1:0]                            req_en_i,
    output logic [NR_BANKS-1:0][NR_OPERAND_QUEUES-1:0]   lane_operand_req_o,
    output logic [NR_BANKS-1:0][NR_GLOBAL_MASTERS-1:0]   ext_operand_req_o,
    input  logic [NR_BANKS-1:0][NR_OPERAND_QUEUES-1:0]   lane_operand_gnt_i,
    input  logic [NR_BANKS-1:0][NR_GLOBAL_MASTERS-1:0]   ext_operand_gnt_i,
    output logic                                         busy_o,
    output logic                                         done_o,
    output logic [31:0]                                  issued_o,
    output logic [31:0]                                  stall_o,
    output logic                                         err_o
);

    gen_state_e r_state;
    gen_state_e w_state_next;
    logic       w_start_ok;

    logic [NR_REQ-1:0][NR_BANKS-1:0] w_col_req;
    logic [NR_REQ-1:0][NR_BANKS-1:0] w_col_gnt;
    logic [NR_REQ-1:0]               w_granted;
    logic [NR_REQ-1:0]               w_empty;
    logic [NR_REQ-1:0]               w_col_any;

    logic [31:0] r_issued;
    logic [31:0] r_stall;
    logic        r_err;
    logic [31:0] w_n_granted;
    logic [31:0] w_n_stall;
    logic [32:0] w_stall_sum;
    logic        w_gnt_err;

    for (genvar j = 0; j < NR_REQ; j++) begin : g_chan
        vrf_req_chan #(
            .NR_BANKS  (NR_BANKS),
            .CNT_WIDTH (CNT_WIDTH),
            .REQ_ID    (j)
        ) u_chan (
            .clk        (clk_i),
            .rst        (rst_i),
            .i_load     (w_start_ok),
            .i_clear    (abort_i),
            .i_budget   (req_en_i[j] ? num_req_i : '0),
            .i_mode     (gen_mode_e'(mode_i)),
            .i_hot_bank (hot_bank_i),
            .i_seed     (seed_i),
            .i_gnt      (w_col_gnt[j]),
            .o_req      (w_col_req[j]),
            .o_granted  (w_granted[j]),
            .o_empty    (w_empty[j])
        );

        assign w_col_any[j] = |w_col_req[j];

        for (genvar b = 0; b < NR_BANKS; b++) begin : g_bank
            if (j < NR_OPERAND_QUEUES) begin : g_lane
                assign lane_operand_req_o[b][j] = w_col_req[j][b];
                assign w_col_gnt[j][b]          = lane_operand_gnt_i[b][j];
            end else begin : g_ext
                assign ext_operand_req_o[b][j-NR_OPERAND_QUEUES] = w_col_req[j][b];
                assign w_col_gnt[j][b] = ext_operand_gnt_i[b][j-NR_OPERAND_QUEUES];
            end
        end
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    // Next state; abort wins over start and start is ignored while running
    always_comb begin
        w_state_next = r_state;
        w_start_ok   = start_i && !abort_i && (r_state != ST_RUN);
        if (abort_i) begin
            w_state_next = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (start_i) w_state_next = ST_RUN;
                ST_RUN:  if (&w_empty) w_state_next = ST_DONE;
                ST_DONE: if (start_i) w_state_next = ST_RUN;
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Per-cycle grant and stall counts plus grants that hit no request
    always_comb begin
        w_n_granted = '0;
        w_n_stall   = '0;
        for (int j = 0; j < NR_REQ; j++) begin
            w_n_granted = w_n_granted + 32'(w_granted[j]);
            w_n_stall   = w_n_stall + 32'(w_col_any[j] & ~w_granted[j]);
        end
        w_stall_sum = {1'b0, r_stall} + {1'b0, w_n_stall};
        w_gnt_err   = (|(lane_operand_gnt_i & ~lane_operand_req_o))
                    | (|(ext_operand_gnt_i & ~ext_operand_req_o));
    end

    // Statistics: cleared by an accepted start, frozen during an abort cycle
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_issued <= '0;
            r_stall  <= '0;
            r_err    <= 1'b0;
        end else if (w_start_ok) begin
            r_issued <= '0;
            r_stall  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= r_err | w_gnt_err;
            if (!abort_i) begin
                r_issued <= r_issued + w_n_granted;
                r_stall  <= w_stall_sum[32] ? 32'hFFFF_FFFF : w_stall_sum[31:0];
            end
        end
    end

    assign busy_o   = (r_state == ST_RUN);
    assign done_o   = (r_state == ST_DONE);
    assign issued_o = r_issued;
    assign stall_o  = r_stall;
    assign err_o    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_vrf_bank_req_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vrf_bank_req_gen
// Description : Self-checking bench for vrf_bank_req_gen: a table of traffic
//               runs checked against a small column model, plus directed
//               sequences for stalls, stray grants, abort and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vrf_bank_req_gen;

    localparam int NB = 8;
    localparam int NQ = 9;
    localparam int NM = 5;
    localparam int NR = NQ + NM;

    typedef logic [NB-1:0] col_t;

    typedef struct {
        logic [1:0]  mode;
        logic [2:0]  hot;
        logic [15:0] seed;
        logic [15:0] num;
        logic [13:0] en;
        int          policy;      // 0: grant every request, 1: grant lowest id only
        int          exp_issued;
        int          exp_stall;
        int          exp_done;    // sample cycle after start where done_o is first seen
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [2:0]  hot = 3'd0;
    logic [15:0] seed = 16'd0;
    logic [15:0] num = 16'd0;
    logic [13:0] en = 14'd0;
    logic [NB-1:0][NQ-1:0] lane_req;
    logic [NB-1:0][NM-1:0] ext_req;
    logic [NB-1:0][NQ-1:0] lane_gnt = '0;
    logic [NB-1:0][NM-1:0] ext_gnt = '0;
    logic        busy, done, err;
    logic [31:0] issued, stall;

    int n_checks = 0;
    int n_errors = 0;

    int          m_budget [NR];
    int          m_k      [NR];
    logic [15:0] m_lfsr   [NR];

    vec_t vecs [9];

    always #5 clk = ~clk;

    vrf_bank_req_gen dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .start_i            (start),
        .abort_i            (abort),
        .mode_i             (mode),
        .hot_bank_i         (hot),
        .seed_i             (seed),
        .num_req_i          (num),
        .req_en_i           (en),
        .lane_operand_req_o (lane_req),
        .ext_operand_req_o  (ext_req),
        .lane_operand_gnt_i (lane_gnt),
        .ext_operand_gnt_i  (ext_gnt),
        .busy_o             (busy),
        .done_o             (done),
        .issued_o           (issued),
        .stall_o            (stall),
        .err_o              (err)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference LFSR: taps at exponents 16,14,13,11, new bit enters at the LSB
    function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
        logic fb;
        fb = s[16-1] ^ s[14-1] ^ s[13-1] ^ s[11-1];
        return {s[14:0], fb};
    endfunction

    function automatic col_t get_col(input int j);
        col_t c;
        for (int b = 0; b < NB; b++) begin
            if (j < NQ) c[b] = lane_req[b][j];
            else        c[b] = ext_req[b][j-NQ];
        end
        return c;
    endfunction

    function automatic logic [127:0] all_req();
        logic [127:0] f = '0;
        for (int j = 0; j < NR; j++) f[j*NB +: NB] = get_col(j);
        return f;
    endfunction

    task automatic drive_gnt(input col_t g [NR]);
        for (int j = 0; j < NR; j++)
            for (int b = 0; b < NB; b++) begin
                if (j < NQ) lane_gnt[b][j] = g[j][b];
                else        ext_gnt[b][j-NQ] = g[j][b];
            end
    endtask

    task automatic clear_gnt();
        lane_gnt = '0;
        ext_gnt  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] md, input logic [2:0] hb, input logic [15:0] sd,
                            input logic [15:0] n, input logic [13:0] e);
        mode = md; hot = hb; seed = sd; num = n; en = e;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    function automatic int model_bank(input logic [1:0] md, input logic [2:0] hb, input int j);
        case (md)
            2'd1:    return int'(hb);
            2'd2:    return int'(m_lfsr[j][2:0]);
            default: return (j + m_k[j]) % NB;
        endcase
    endfunction

    task automatic run_vec(input vec_t v, input string tag);
        col_t act [NR];
        col_t expc [NR];
        col_t g [NR];
        logic [127:0] act_f, exp_f;
        logic [15:0] s;
        int c;
        bit fin, first;
        for (int j = 0; j < NR; j++) begin
            m_budget[j] = v.en[j] ? int'(v.num) : 0;
            m_k[j]      = 0;
            s           = v.seed ^ 16'(j);
            m_lfsr[j]   = (s == 16'd0) ? 16'd1 : s;
        end
        do_start(v.mode, v.hot, v.seed, v.num, v.en);
        c = 1;
        fin = 1'b0;
        while (!fin && c < 400) begin
            if (done) begin
                fin = 1'b1;
            end else begin
                act_f = '0;
                exp_f = '0;
                first = 1'b1;
                for (int j = 0; j < NR; j++) begin
                    act[j]  = get_col(j);
                    expc[j] = '0;
                    if (m_budget[j] > 0) expc[j][model_bank(v.mode, v.hot, j)] = 1'b1;
                    act_f[j*NB +: NB] = act[j];
                    exp_f[j*NB +: NB] = expc[j];
                end
                chk({tag, "_req"}, act_f, exp_f);
                chk({tag, "_busy"}, 128'(busy), 128'd1);
                for (int j = 0; j < NR; j++) begin
                    if (v.policy == 0) begin
                        g[j] = act[j];
                    end else if (first && act[j] != '0) begin
                        g[j]  = act[j];
                        first = 1'b0;
                    end else begin
                        g[j] = '0;
                    end
                end
                drive_gnt(g);
                for (int j = 0; j < NR; j++) begin
                    if ((g[j] & expc[j]) != '0) begin
                        m_budget[j]--;
                        m_k[j]++;
                        m_lfsr[j] = ref_lfsr(m_lfsr[j]);
                    end
                end
                step();
                c++;
            end
        end
        clear_gnt();
        chk({tag, "_done_cycle"}, 128'(c), 128'(v.exp_done));
        chk({tag, "_issued"}, 128'(issued), 128'(v.exp_issued));
        chk({tag, "_stall"}, 128'(stall), 128'(v.exp_stall));
        chk({tag, "_err"}, 128'(err), 128'd0);
        chk({tag, "_idle_req"}, all_req(), 128'd0);
    endtask

    initial begin
        vec_t v;
        vecs[0] = '{mode: 2'd0, hot: 3'd0, seed: 16'h0000, num: 16'd3,   en: 14'h3FFF, policy: 0, exp_issued: 42,  exp_stall: 0,   exp_done: 5};
        vecs[1] = '{mode: 2'd1, hot: 3'd2, seed: 16'h0000, num: 16'd1,   en: 14'h3FFF, policy: 1, exp_issued: 14,  exp_stall: 91,  exp_done: 16};
        vecs[2] = '{mode: 2'd2, hot: 3'd0, seed: 16'hACE1, num: 16'd100, en: 14'h0001, policy: 0, exp_issued: 100, exp_stall: 0,   exp_done: 102};
        vecs[3] = '{mode: 2'd2, hot: 3'd0, seed: 16'h0000, num: 16'd4,   en: 14'h0001, policy: 0, exp_issued: 4,   exp_stall: 0,   exp_done: 6};
        vecs[4] = '{mode: 2'd0, hot: 3'd0, seed: 16'h0000, num: 16'd0,   en: 14'h3FFF, policy: 0, exp_issued: 0,   exp_stall: 0,   exp_done: 2};
        vecs[5] = '{mode: 2'd0, hot: 3'd0, seed: 16'h0000, num: 16'd5,   en: 14'h0000, policy: 0, exp_issued: 0,   exp_stall: 0,   exp_done: 2};
        vecs[6] = '{mode: 2'd0, hot: 3'd0, seed: 16'h0000, num: 16'd2,   en: 14'h0101, policy: 0, exp_issued: 4,   exp_stall: 0,   exp_done: 4};
        vecs[7] = '{mode: 2'd3, hot: 3'd0, seed: 16'h0000, num: 16'd2,   en: 14'h3FFF, policy: 0, exp_issued: 28,  exp_stall: 0,   exp_done: 4};
        vecs[8] = '{mode: 2'd1, hot: 3'd7, seed: 16'h0000, num: 16'd2,   en: 14'h3FFF, policy: 1, exp_issued: 28,  exp_stall: 182, exp_done: 30};

        // Reset values while reset is held
        step();
        step();
        chk("rst_req", all_req(), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_issued", 128'(issued), 128'd0);
        chk("rst_stall", 128'(stall), 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Grant withheld on queue 0 for 5 cycles
        do_start(2'd0, 3'd0, 16'd0, 16'd2, 14'h0001);
        for (int i = 0; i < 5; i++) begin
            chk("hold_req", 128'(get_col(0)), 128'h01);
            step();
        end
        chk("hold_stall", 128'(stall), 128'd5);
        chk("hold_req_still", 128'(get_col(0)), 128'h01);
        chk("hold_issued", 128'(issued), 128'd0);
        lane_gnt[0][0] = 1'b1;
        step();
        clear_gnt();
        chk("hold_next_bank", 128'(get_col(0)), 128'h02);
        chk("hold_issued1", 128'(issued), 128'd1);
        chk("hold_stall_after", 128'(stall), 128'd5);
        lane_gnt[1][0] = 1'b1;
        step();
        clear_gnt();
        chk("hold_drop", 128'(get_col(0)), 128'h00);
        chk("hold_issued2", 128'(issued), 128'd2);
        step();
        chk("hold_done", 128'(done), 128'd1);

        // Grant on a bank that is not requested
        do_start(2'd0, 3'd0, 16'd0, 16'd2, 14'h0001);
        lane_gnt[5][0] = 1'b1;
        step();
        clear_gnt();
        chk("err_set", 128'(err), 128'd1);
        chk("err_issued", 128'(issued), 128'd0);
        chk("err_req_kept", 128'(get_col(0)), 128'h01);
        step();
        chk("err_sticky", 128'(err), 128'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("err_abort_keep", 128'(err), 128'd1);
        chk("err_abort_busy", 128'(busy), 128'd0);
        chk("err_abort_req", all_req(), 128'd0);
        do_start(2'd0, 3'd0, 16'd0, 16'd1, 14'h0001);
        chk("err_cleared", 128'(err), 128'd0);
        lane_gnt[0][0] = 1'b1;
        step();
        clear_gnt();
        step();
        chk("err_rerun_done", 128'(done), 128'd1);
        chk("err_rerun_issued", 128'(issued), 128'd1);

        // Abort in mid-run
        do_start(2'd0, 3'd0, 16'd0, 16'd10, 14'h3FFF);
        for (int i = 0; i < 2; i++) begin
            lane_gnt = lane_req;
            ext_gnt  = ext_req;
            step();
        end
        clear_gnt();
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_req", all_req(), 128'd0);
        chk("abort_busy", 128'(busy), 128'd0);
        chk("abort_done", 128'(done), 128'd0);
        chk("abort_issued", 128'(issued), 128'd28);

        // Start while running is ignored
        do_start(2'd0, 3'd0, 16'd0, 16'd3, 14'h0001);
        step();
        step();
        num = 16'd1; en = 14'h3FFF; start = 1'b1;
        step();
        start = 1'b0;
        chk("ign_busy", 128'(busy), 128'd1);
        chk("ign_stall", 128'(stall), 128'd3);
        chk("ign_req", all_req(), 128'h01);
        for (int i = 0; i < 3; i++) begin
            lane_gnt = lane_req;
            ext_gnt  = ext_req;
            step();
        end
        clear_gnt();
        chk("ign_issued", 128'(issued), 128'd3);
        chk("ign_not_done", 128'(done), 128'd0);
        step();
        chk("ign_done", 128'(done), 128'd1);

        // Asynchronous reset mid-run
        do_start(2'd0, 3'd0, 16'd0, 16'd4, 14'h3FFF);
        lane_gnt = lane_req;
        ext_gnt  = ext_req;
        step();
        clear_gnt();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_req", all_req(), 128'd0);
        chk("arst_busy", 128'(busy), 128'd0);
        chk("arst_issued", 128'(issued), 128'd0);
        step();
        rst = 1'b0;
        step();
        v = '{mode: 2'd0, hot: 3'd0, seed: 16'h0000, num: 16'd2, en: 14'h0001, policy: 0, exp_issued: 2, exp_stall: 0, exp_done: 4};
        run_vec(v, "rerun");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
